// File: rtl/sequential_multiply_add.sv
// Iterative unsigned multiply-accumulate: result = multiplicand * multiplier + addend.
// One shift-add step per enabled edge, then a single accumulate edge.
module sequential_multiply_add #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      clk_en_i,
  input  logic                      rst_n_i,
  input  logic [DATA_WIDTH-1:0]     multiplicand_i,
  input  logic [DATA_WIDTH-1:0]     multiplier_i,
  input  logic [DATA_WIDTH-1:0]     addend_i,
  input  logic                      data_valid_i,
  output logic [2*DATA_WIDTH-1:0]   result_o,
  output logic                      data_valid_o,
  output logic                      idle_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned RES_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULTIPLY,
    S_ACCUMULATE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [W-1:0]       m, m_nxt;
  logic [W-1:0]       addend, addend_nxt;
  logic [W:0]         a, a_nxt;
  logic [W-1:0]       q, q_nxt;
  logic [RES_W-1:0]   result_nxt;
  logic               data_valid_nxt;
  logic               idle_nxt;
  logic [W:0]         sum;

  // State and datapath registers; reset wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      m            <= '0;
      addend       <= '0;
      a            <= '0;
      q            <= '0;
      result_o     <= '0;
      data_valid_o <= 1'b0;
      idle_o       <= 1'b1;
    end else if (clk_en_i) begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      m            <= m_nxt;
      addend       <= addend_nxt;
      a            <= a_nxt;
      q            <= q_nxt;
      result_o     <= result_nxt;
      data_valid_o <= data_valid_nxt;
      idle_o       <= idle_nxt;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    m_nxt          = m;
    addend_nxt     = addend;
    a_nxt          = a;
    q_nxt          = q;
    result_nxt     = result_o;
    data_valid_nxt = 1'b0;
    sum            = a;

    case (state)
      S_IDLE: begin
        if (data_valid_i) begin
          m_nxt      = multiplicand_i;
          q_nxt      = multiplier_i;
          addend_nxt = addend_i;
          a_nxt      = '0;
          cnt_nxt    = '0;
          state_nxt  = S_MULTIPLY;
        end
      end

      S_MULTIPLY: begin
        // A stays below 2^W after every shift, so A + M fits in W+1 bits.
        if (q[0]) begin
          sum = a + {1'b0, m};
        end
        a_nxt   = {1'b0, sum[W:1]};
        q_nxt   = {sum[0], q[W-1:1]};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(W - 1)) begin
          state_nxt = S_ACCUMULATE;
        end
      end

      S_ACCUMULATE: begin
        result_nxt     = {a[W-1:0], q} + RES_W'(addend);
        data_valid_nxt = 1'b1;
        state_nxt      = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    idle_nxt = (state_nxt == S_IDLE);
  end

endmodule

// File: tb/tb_sequential_multiply_add.sv
// Self-checking bench for sequential_multiply_add: directed cases plus random
// operations checked against a plain-arithmetic reference.
module tb_sequential_multiply_add;

  localparam int unsigned W = 16;

  logic             clk_i = 1'b0;
  logic             clk_en_i;
  logic             rst_n_i;
  logic [W-1:0]     multiplicand_i;
  logic [W-1:0]     multiplier_i;
  logic [W-1:0]     addend_i;
  logic             data_valid_i;
  logic [2*W-1:0]   result_o;
  logic             data_valid_o;
  logic             idle_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] last_result;

  sequential_multiply_add #(.DATA_WIDTH(W)) dut (
    .clk_i          (clk_i),
    .clk_en_i       (clk_en_i),
    .rst_n_i        (rst_n_i),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .addend_i       (addend_i),
    .data_valid_i   (data_valid_i),
    .result_o       (result_o),
    .data_valid_o   (data_valid_o),
    .idle_o         (idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mac(input logic [W-1:0] mc, mp, ad);
    longint unsigned r;
    r = longint'(mc) * longint'(mp) + longint'(ad);
    return (2*W)'(r);
  endfunction

  // One full operation. accepted=1 means the accept edge already happened
  // (chained start in the previous completion cycle). poke_* re-assert
  // data_valid_i with junk operands at those busy edges; stall_e freezes
  // clk_en_i for 5 cycles before that busy edge; stall_dv freezes during the pulse.
  task automatic op(input logic [W-1:0] mc, mp, ad, input bit accepted,
                    input int poke_a, poke_b, stall_e, input bit stall_dv,
                    input bit chain, input logic [W-1:0] nmc, nmp, nad);
    logic [2*W-1:0] exp;
    exp = ref_mac(mc, mp, ad);
    if (!accepted) begin
      multiplicand_i = mc; multiplier_i = mp; addend_i = ad;
      data_valid_i = 1'b1;
      tick();
    end
    data_valid_i = 1'b0;
    check("accept_idle", 64'(idle_o), 64'd0);
    check("accept_dv", 64'(data_valid_o), 64'd0);
    for (int e = 1; e <= int'(W); e++) begin
      if (e == stall_e) begin
        clk_en_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_busy_idle", 64'(idle_o), 64'd0);
        end
        clk_en_i = 1'b1;
      end
      if (e == poke_a || e == poke_b) begin
        multiplicand_i = W'($urandom); multiplier_i = W'($urandom);
        addend_i = W'($urandom); data_valid_i = 1'b1;
      end
      tick();
      data_valid_i = 1'b0;
      check("busy_dv", 64'(data_valid_o), 64'd0);
      check("busy_idle", 64'(idle_o), 64'd0);
      check("busy_result_hold", 64'(result_o), 64'(last_result));
    end
    tick();
    check("done_result", 64'(result_o), 64'(exp));
    check("done_dv", 64'(data_valid_o), 64'd1);
    check("done_idle", 64'(idle_o), 64'd1);
    last_result = exp;
    if (stall_dv) begin
      clk_en_i = 1'b0;
      for (int s = 0; s < 5; s++) begin
        tick();
        check("stall_dv_hold", 64'(data_valid_o), 64'd1);
        check("stall_dv_result", 64'(result_o), 64'(exp));
      end
      clk_en_i = 1'b1;
    end
    if (chain) begin
      multiplicand_i = nmc; multiplier_i = nmp; addend_i = nad;
      data_valid_i = 1'b1;
      tick();
    end else begin
      tick();
      check("post_dv", 64'(data_valid_o), 64'd0);
      check("post_result", 64'(result_o), 64'(exp));
    end
  endtask

  initial begin
    logic [W-1:0] cmc, cmp_, cad, nmc, nmp, nad;
    bit acc, chn;
    clk_en_i = 1'b1; rst_n_i = 1'b0; data_valid_i = 1'b0;
    multiplicand_i = '0; multiplier_i = '0; addend_i = '0;
    last_result = '0;
    tick(); tick();
    check("reset_idle", 64'(idle_o), 64'd1);
    check("reset_dv", 64'(data_valid_o), 64'd0);
    check("reset_result", 64'(result_o), 64'd0);
    rst_n_i = 1'b1;
    tick();

    op(16'h1234, 16'h0010, 16'h0005, 1'b0, 0, 0, 0, 1'b0, 1'b0, '0, '0, '0);
    check("basic_value", 64'(result_o), 64'h0001_2345);
    op(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 0, 1'b0, 1'b0, '0, '0, '0);
    check("max_value", 64'(result_o), 64'hFFFF_0000);
    op(16'h0000, 16'hABCD, 16'h0007, 1'b0, 0, 0, 0, 1'b0, 1'b0, '0, '0, '0);
    check("zero_value", 64'(result_o), 64'h0000_0007);
    op(16'd142, 16'd7, 16'd6, 1'b0, 0, 0, 0, 1'b0, 1'b0, '0, '0, '0);
    check("roundtrip_value", 64'(result_o), 64'd1000);

    // Busy rejection, then a start accepted in the completion cycle.
    op(16'd3, 16'd5, 16'd1, 1'b0, 4, 10, 0, 1'b0, 1'b1, 16'd9, 16'd11, 16'd2);
    check("busy_reject_value", 64'(last_result), 64'd16);
    op(16'd9, 16'd11, 16'd2, 1'b1, 0, 0, 0, 1'b0, 1'b0, '0, '0, '0);
    check("chained_value", 64'(result_o), 64'd101);

    // Clock-enable stalls mid-multiply and during the pulse.
    op(16'hBEEF, 16'h1357, 16'h2468, 1'b0, 0, 0, 7, 1'b1, 1'b0, '0, '0, '0);

    // Reset at busy edge 8 discards the operation.
    multiplicand_i = 16'h0102; multiplier_i = 16'h0304; addend_i = 16'h0506;
    data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    for (int e = 1; e < 8; e++) tick();
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    check("midrst_idle", 64'(idle_o), 64'd1);
    check("midrst_dv", 64'(data_valid_o), 64'd0);
    check("midrst_result", 64'(result_o), 64'd0);
    last_result = '0;
    for (int c = 0; c < int'(W) + 4; c++) begin
      tick();
      check("midrst_no_pulse", 64'(data_valid_o), 64'd0);
    end

    // Randomized operations with random pokes and occasional chaining.
    cmc = W'($urandom); cmp_ = W'($urandom); cad = W'($urandom);
    acc = 1'b0;
    for (int i = 0; i < 24; i++) begin
      nmc = W'($urandom); nmp = W'($urandom); nad = W'($urandom);
      chn = (i != 23) && ($urandom_range(0, 1) == 1);
      op(cmc, cmp_, cad, acc, int'($urandom_range(0, W)), int'($urandom_range(0, W)),
         0, 1'b0, chn, nmc, nmp, nad);
      acc = chn;
      cmc = nmc; cmp_ = nmp; cad = nad;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sequential_multiply_add.md
Name: sequential_multiply_add

Overview:
- Iterative unsigned multiply-accumulate; computes result = multiplicand × multiplier + addend over DATA_WIDTH shift-add iterations plus one accumulate cycle.
- Inverse companion of the iterative divider: reconstructs dividend = quotient × divisor + remainder. Used for divide-result checking and as the datapath's standalone multiplier.
- Same start/done handshake style as the divider (data_valid_i pulse in, data_valid_o pulse out, idle_o level).

Parameters:
- DATA_WIDTH, 16, operand width in bits; power of 2, ≥ 2.

Ports:
- clk_i  input  1  clock, rising edge
- clk_en_i  input  1  clock enable; low freezes every register, including state, counter, outputs and status
- rst_n_i  input  1  reset, synchronous, active-low
- multiplicand_i  input  DATA_WIDTH  unsigned multiplicand, sampled at accept
- multiplier_i  input  DATA_WIDTH  unsigned multiplier, sampled at accept
- addend_i  input  DATA_WIDTH  unsigned addend, sampled at accept
- data_valid_i  input  1  start request; honoured only in IDLE
- result_o  output  2*DATA_WIDTH  registered result; holds value until next completion
- data_valid_o  output  1  one-cycle completion pulse
- idle_o  output  1  high when ready to accept

Behaviour:
- Reset (rst_n_i low at a clock edge, regardless of clk_en_i or state):
  - state = IDLE, data_valid_o = 0, idle_o = 1, result_o = 0.
  - Any in-flight operation is discarded with no completion pulse.
- Counter: $clog2(DATA_WIDTH) bits. Internal registers: multiplicand M (W bits), addend (W bits), accumulator A (W+1 bits), multiplier/low-product Q (W bits).
- Accept ("edge 0"): rising edge with clk_en_i = 1, state IDLE, data_valid_i = 1.
  - Captures M, Q = multiplier_i, addend; sets A = 0 and counter = 0.
  - state → MULTIPLY; idle_o → 0.
  - data_valid_i is a level sample: holding it high continuously causes back-to-back operations.
- MULTIPLY (edges 1..W):
  - If Q[0] = 1, form {A,Q} = {A + M, Q}; otherwise leave {A,Q} unchanged.
  - Logically shift the (2W+1)-bit {A,Q} right by 1; counter += 1.
  - The carry is kept in A[W], so no overflow is lost.
  - After the W-th iteration ({A,Q} holds the full product) state → ACCUMULATE.
- ACCUMULATE (edge W+1):
  - result_o = {A[W-1:0], Q} + zero-extended addend.
  - Cannot overflow: the maximum value is 2^(2W) − 2^W.
  - data_valid_o → 1, idle_o → 1, state → IDLE.
- Latency: data_valid_o is high exactly in the cycle after edge W+1 and low again after the next enabled edge. Edges are counted only when clk_en_i = 1.
- result_o does not change during MULTIPLY or ACCUMULATE; it updates only at the ACCUMULATE edge.
- data_valid_i while not IDLE: ignored; the in-flight operation is unaffected.
- Acceptance in the completion cycle: the cycle where data_valid_o = 1 is already IDLE, so data_valid_i there is accepted (0 dead cycles between operations).
- Zero operands: a zero multiplicand or multiplier is legal; the result is the addend. There is no error flag.
- clk_en_i low: all state holds, including data_valid_o. A pulse stays high until the next enabled edge.

Test Plan:
- W=16: multiplicand 0x1234, multiplier 0x0010, addend 0x0005, pulse data_valid_i → result_o = 0x00012345; data_valid_o high for exactly 1 cycle after the 17th enabled edge following accept; idle_o low for edges 1–16.
- Max: 0xFFFF × 0xFFFF + 0xFFFF → result_o = 0xFFFF0000; zero case 0x0000 × 0xABCD + 0x0007 → 0x00000007.
- Divider round trip: quotient 142, divisor 7, remainder 6 → result_o = 1000 (0x000003E8).
- Busy rejection: start 3 × 5 + 1, re-assert data_valid_i with other operands at edges 4 and 10 → single completion, result_o = 16, old result_o stable until then; a start issued in the data_valid_o cycle is accepted.
- Reset mid-operation: assert rst_n_i low at edge 8 → next cycle state IDLE, idle_o = 1, data_valid_o = 0, result_o = 0; no pulse ever appears for that operation.
- clk_en_i stall: drop clk_en_i for 5 cycles mid-MULTIPLY and again while data_valid_o = 1 → result is correct, the pulse stretches over the stall, and the total enabled-edge count is unchanged.
